// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM latch: ALU, branch target, HI/LO mux, iterative MULTU/DIVU (enabled by MULDIV_EN).
// One cycle to the latch; stall is high for the 32 busy cycles and the latch loads bubbles meanwhile.
module ex_mem_stage #(
    parameter int len_data    = 32,
    parameter int num_bits    = 5,
    parameter int len_mem_bus = 9,
    parameter int len_wb_bus  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [len_data-1:0]    in_pc_next,
    input  logic [len_data-1:0]    in_rs_data,
    input  logic [len_data-1:0]    in_rt_data,
    input  logic [len_data-1:0]    in_imm,
    input  logic [4:0]             in_shamt,
    input  logic [num_bits-1:0]    in_rt_addr,
    input  logic [num_bits-1:0]    in_rd_addr,
    input  logic [3:0]             in_alu_op,
    input  logic                   in_alu_src,
    input  logic                   in_reg_dst,
    input  logic                   in_md_start,
    input  logic                   in_md_op,
    input  logic [1:0]             in_hilo_sel,
    input  logic [len_mem_bus-1:0] in_mem_bus,
    input  logic [len_wb_bus-1:0]  in_wb_bus,
    input  logic                   in_halt,
    input  logic                   flush,
    output logic [len_data-1:0]    out_alu_result,
    output logic [len_data-1:0]    out_write_data,
    output logic [len_mem_bus-1:0] out_mem_bus,
    output logic [len_wb_bus-1:0]  out_wb_bus,
    output logic [num_bits-1:0]    out_write_reg,
    output logic                   out_zero,
    output logic [len_data-1:0]    out_pc_branch,
    output logic                   out_halt,
    output logic                   stall
);

    logic [len_data-1:0] op_a, op_b, alu_res, result, hi_rd, lo_rd;

    assign op_a = in_rs_data;
    assign op_b = in_alu_src ? in_imm : in_rt_data;

    always_comb begin
        alu_res = '0;
        case (in_alu_op)
            4'd0:  alu_res = op_a + op_b;
            4'd1:  alu_res = op_a - op_b;
            4'd2:  alu_res = op_a & op_b;
            4'd3:  alu_res = op_a | op_b;
            4'd4:  alu_res = op_a ^ op_b;
            4'd5:  alu_res = ~(op_a | op_b);
            4'd6:  alu_res = {{(len_data-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd7:  alu_res = {{(len_data-1){1'b0}}, op_a < op_b};
            4'd8:  alu_res = op_b << in_shamt;
            4'd9:  alu_res = op_b >> in_shamt;
            4'd10: alu_res = $unsigned($signed(op_b) >>> in_shamt);
            // Variable shifts move operand A by the low five bits of operand B.
            4'd11: alu_res = op_a << op_b[4:0];
            4'd12: alu_res = op_a >> op_b[4:0];
            4'd13: alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            4'd14: alu_res = {op_b[15:0], 16'h0000};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (in_hilo_sel)
            2'b01:   result = hi_rd;
            2'b10:   result = lo_rd;
            default: result = alu_res;
        endcase
    end

`ifdef MULDIV_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                md_op_q, md_op_d;
    logic [len_data-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
    logic [len_data-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [len_data:0]   mul_sum, div_shift, div_sub;
    logic                div_ge;
    logic [len_data-1:0] step_hi, step_lo;

    // MULTU: acc_lo holds the multiplier and collects product low bits as it shifts out.
    // DIVU: acc_hi is the partial remainder, acc_lo the dividend becoming the quotient.
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(len_data+1){1'b0}});
    assign div_shift = {acc_hi_q, acc_lo_q[len_data-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift - {1'b0, opnd_q};

    always_comb begin
        if (md_op_q) begin
            step_hi = div_ge ? div_sub[len_data-1:0] : div_shift[len_data-1:0];
            step_lo = {acc_lo_q[len_data-2:0], div_ge};
        end else begin
            step_hi = mul_sum[len_data:1];
            step_lo = {mul_sum[0], acc_lo_q[len_data-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_op_d  = md_op_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (in_md_start && !flush) begin
                    state_d  = BUSY;
                    cnt_d    = 6'd32;
                    md_op_d  = in_md_op;
                    acc_hi_d = '0;
                    acc_lo_d = in_md_op ? in_rs_data : in_rt_data;
                    opnd_d   = in_md_op ? in_rt_data : in_rs_data;
                end
            end
            BUSY: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = IDLE;
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            md_op_q  <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            md_op_q  <= md_op_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi_rd = hi_q;
    assign lo_rd = lo_q;
    assign stall = (state_q == BUSY);
`else
    logic unused_md;
    assign unused_md = &{1'b0, in_md_start, in_md_op};
    assign hi_rd     = '0;
    assign lo_rd     = '0;
    assign stall     = 1'b0;
`endif

    logic [len_data-1:0]    alu_q, wdata_q, pcb_q;
    logic [len_mem_bus-1:0] mem_q;
    logic [len_wb_bus-1:0]  wb_q;
    logic [num_bits-1:0]    wreg_q;
    logic                   zero_q, halt_q;

    // Stall bubbles and flush bubbles are identical, so one branch covers both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || 1'b0) begin
            alu_q   <= '0;
            wdata_q <= '0;
            pcb_q   <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            wreg_q  <= '0;
            zero_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else if (stall || flush) begin
            alu_q   <= '0;
            wdata_q <= '0;
            pcb_q   <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            wreg_q  <= '0;
            zero_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            alu_q   <= result;
            wdata_q <= in_rt_data;
            pcb_q   <= in_pc_next + (in_imm << 2);
            mem_q   <= in_mem_bus;
            wb_q    <= in_wb_bus;
            wreg_q  <= in_reg_dst ? in_rd_addr : in_rt_addr;
            zero_q  <= (result == '0);
            halt_q  <= in_halt;
        end
    end

    assign out_alu_result = alu_q;
    assign out_write_data = wdata_q;
    assign out_pc_branch  = pcb_q;
    assign out_mem_bus    = mem_q;
    assign out_wb_bus     = wb_q;
    assign out_write_reg  = wreg_q;
    assign out_zero       = zero_q;
    assign out_halt       = halt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage; MULTU/DIVU expectations follow whether MULDIV_EN is defined.
module tb_ex_mem_stage;

`ifdef MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_pc_next, in_rs_data, in_rt_data, in_imm;
    logic [4:0]  in_shamt, in_rt_addr, in_rd_addr;
    logic [3:0]  in_alu_op;
    logic        in_alu_src, in_reg_dst, in_md_start, in_md_op, in_halt, flush;
    logic [1:0]  in_hilo_sel, in_wb_bus;
    logic [8:0]  in_mem_bus;
    logic [31:0] out_alu_result, out_write_data, out_pc_branch;
    logic [8:0]  out_mem_bus;
    logic [1:0]  out_wb_bus;
    logic [4:0]  out_write_reg;
    logic        out_zero, out_halt, stall;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset),
        .in_pc_next(in_pc_next), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_shamt(in_shamt), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
        .in_alu_op(in_alu_op), .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst),
        .in_md_start(in_md_start), .in_md_op(in_md_op), .in_hilo_sel(in_hilo_sel),
        .in_mem_bus(in_mem_bus), .in_wb_bus(in_wb_bus), .in_halt(in_halt), .flush(flush),
        .out_alu_result(out_alu_result), .out_write_data(out_write_data),
        .out_mem_bus(out_mem_bus), .out_wb_bus(out_wb_bus), .out_write_reg(out_write_reg),
        .out_zero(out_zero), .out_pc_branch(out_pc_branch), .out_halt(out_halt), .stall(stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        in_pc_next = 0; in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_shamt = 0;
        in_rt_addr = 0; in_rd_addr = 0; in_alu_op = 0; in_alu_src = 0; in_reg_dst = 0;
        in_md_start = 0; in_md_op = 0; in_hilo_sel = 0; in_mem_bus = 0; in_wb_bus = 0;
        in_halt = 0; flush = 0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        nop();
        in_alu_op = op; in_rs_data = rs; in_rt_data = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges while stall is high; every one of those edges must latch a bubble.
    task automatic wait_md(input string tag);
        n = 0;
        while (stall && n < 100) begin
            tick();
            n++;
            chk({tag, "_bubble_wb"}, {30'd0, out_wb_bus}, 32'd0);
            chk({tag, "_bubble_mem"}, {23'd0, out_mem_bus}, 32'd0);
        end
        chk({tag, "_stall_cycles"}, n, MD ? 32'd32 : 32'd0);
    endtask

    initial begin
        nop();
        in_mem_bus = 9'h1FF; in_wb_bus = 2'b11; in_halt = 1'b1; in_rs_data = 32'h55;
        reset = 1'b1;
        #12;
        chk("rst_result", out_alu_result, 0);
        chk("rst_mem", {23'd0, out_mem_bus}, 0);
        chk("rst_wb_halt_zero", {29'd0, out_wb_bus, out_halt}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        @(negedge clk);
        reset = 1'b0;

        alu(4'd0, 32'd5, 32'd7);
        in_reg_dst = 1; in_rd_addr = 5'd3; in_rt_addr = 5'd9;
        in_mem_bus = 9'h1A5; in_wb_bus = 2'b10; in_halt = 1'b0;
        tick();
        chk("add_result", out_alu_result, 32'd12);
        chk("add_wreg", {27'd0, out_write_reg}, 32'd3);
        chk("add_zero", {31'd0, out_zero}, 32'd0);
        chk("add_mem", {23'd0, out_mem_bus}, 32'h1A5);
        chk("add_wb", {30'd0, out_wb_bus}, 32'd2);
        chk("add_wdata", out_write_data, 32'd7);

        alu(4'd1, 32'd9, 32'd9);
        in_pc_next = 32'h100; in_imm = 32'd4; in_rt_addr = 5'd6; in_halt = 1'b1;
        tick();
        chk("sub_zero", {31'd0, out_zero}, 32'd1);
        chk("sub_pcb", out_pc_branch, 32'h110);
        chk("sub_wreg", {27'd0, out_write_reg}, 32'd6);
        chk("sub_halt", {31'd0, out_halt}, 32'd1);

        alu(4'd10, 32'h12345678, 32'h80000000); in_shamt = 5'd4;
        tick(); chk("sra", out_alu_result, 32'hF8000000);
        alu(4'd6, 32'hFFFFFFFF, 32'd1);
        tick(); chk("slt", out_alu_result, 32'd1);
        alu(4'd7, 32'hFFFFFFFF, 32'd1);
        tick(); chk("sltu", out_alu_result, 32'd0);
        chk("sltu_zero", {31'd0, out_zero}, 32'd1);
        alu(4'd0, 32'd10, 32'd0); in_alu_src = 1; in_imm = 32'hFFFFFFFE;
        tick(); chk("addi", out_alu_result, 32'd8);
        alu(4'd14, 32'd0, 32'd0); in_alu_src = 1; in_imm = 32'h00001234;
        tick(); chk("lui", out_alu_result, 32'h12340000);
        alu(4'd5, 32'h0F0F0000, 32'h000000F0);
        tick(); chk("nor", out_alu_result, 32'hF0F0FF0F);
        alu(4'd12, 32'h00000080, 32'h00000023);
        tick(); chk("srlv", out_alu_result, 32'h00000010);
        alu(4'd13, 32'h80000000, 32'd31);
        tick(); chk("srav", out_alu_result, 32'hFFFFFFFF);
        alu(4'd8, 32'hFFFFFFFF, 32'h00000003); in_shamt = 5'd2;
        tick(); chk("sll", out_alu_result, 32'h0000000C);
        alu(4'd15, 32'h1, 32'h2);
        tick(); chk("op15", out_alu_result, 32'd0);

        alu(4'd0, 32'd1, 32'd2); in_wb_bus = 2'b11; in_mem_bus = 9'h0F0; in_halt = 1; flush = 1;
        tick();
        chk("flush_result", out_alu_result, 0);
        chk("flush_ctl", {21'd0, out_mem_bus, out_wb_bus, out_halt}, 0);

        // MULTU 0xFFFFFFFF x 2 passes through as an ADD with wb = 0.
        alu(4'd0, 32'hFFFFFFFF, 32'd2); in_md_start = 1; in_md_op = 0;
        tick();
        chk("mul_pass", out_alu_result, 32'd1);
        chk("mul_stall", {31'd0, stall}, {31'd0, MD});
        alu(4'd0, 32'd0, 32'd0); in_hilo_sel = 2'b01; in_wb_bus = 2'b01; in_mem_bus = 9'h011;
        wait_md("mul");
        tick();
        chk("mfhi_mul", out_alu_result, MD ? 32'd1 : 32'd0);
        chk("mfhi_wb", {30'd0, out_wb_bus}, 32'd1);
        in_hilo_sel = 2'b10;
        tick();
        chk("mflo_mul", out_alu_result, MD ? 32'hFFFFFFFE : 32'd0);

        alu(4'd0, 32'd100, 32'd7); in_md_start = 1; in_md_op = 1;
        tick();
        nop(); in_hilo_sel = 2'b10;
        wait_md("div");
        tick(); chk("mflo_div", out_alu_result, MD ? 32'd14 : 32'd0);
        in_hilo_sel = 2'b01;
        tick(); chk("mfhi_div", out_alu_result, MD ? 32'd2 : 32'd0);

        alu(4'd0, 32'd5, 32'd0); in_md_start = 1; in_md_op = 1;
        tick();
        nop(); in_hilo_sel = 2'b10;
        wait_md("div0");
        tick(); chk("mflo_div0", out_alu_result, MD ? 32'hFFFFFFFF : 32'd0);
        in_hilo_sel = 2'b01;
        tick(); chk("mfhi_div0", out_alu_result, MD ? 32'd5 : 32'd0);

        alu(4'd0, 32'd3, 32'd3); in_md_start = 1; flush = 1;
        tick();
        chk("flush_md_stall", {31'd0, stall}, 0);
        nop(); in_hilo_sel = 2'b01;
        tick(); chk("flush_md_hi", out_alu_result, MD ? 32'd5 : 32'd0);

        // Reset ten cycles into a MULTU.
        alu(4'd0, 32'd3, 32'd3); in_md_start = 1;
        tick();
        nop(); in_hilo_sel = 2'b01; in_wb_bus = 2'b11;
        repeat (10) tick();
        chk("pre_rst_stall", {31'd0, stall}, {31'd0, MD});
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 0);
        chk("mid_rst_outs", {out_alu_result[22:0], out_mem_bus}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_stall", {31'd0, stall}, 0);
        chk("post_rst_hi", out_alu_result, 0);
        chk("post_rst_wb", {30'd0, out_wb_bus}, 32'd3);
        in_hilo_sel = 2'b10;
        tick();
        chk("post_rst_lo", out_alu_result, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline latch of the 5-stage MIPS core.
- Takes decoded operands and control from the ID/EX latch, computes the ALU result, branch target and zero flag, and selects the destination register.
- Registers these values for the memory/write-back latch, which consumes address, store data, mem/wb buses, zero flag and branch target.
- Contains an iterative 32-cycle MULTU/DIVU unit with HI/LO registers; it stalls upstream while busy.

Parameters:
- len_data, 32, datapath width
- num_bits, 5, register address width
- len_mem_bus, 9, memory control bus width, passed through untouched
- len_wb_bus, 2, write-back control bus width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_pc_next  in  len_data  PC+4 of instruction
- in_rs_data  in  len_data  operand A
- in_rt_data  in  len_data  operand B / store data
- in_imm  in  len_data  sign-extended immediate
- in_shamt  in  5  shift amount
- in_rt_addr  in  num_bits  rt field
- in_rd_addr  in  num_bits  rd field
- in_alu_op  in  4  ALU operation
- in_alu_src  in  1  1 = operand B is in_imm
- in_reg_dst  in  1  1 = destination is rd, else rt
- in_md_start  in  1  start MULTU/DIVU
- in_md_op  in  1  0 = MULTU, 1 = DIVU
- in_hilo_sel  in  2  00 ALU, 01 HI, 10 LO, 11 ALU
- in_mem_bus  in  len_mem_bus  memory control
- in_wb_bus  in  len_wb_bus  write-back control
- in_halt  in  1  halt flag
- flush  in  1  squash instruction in execute
- out_alu_result  out  len_data  result / memory address
- out_write_data  out  len_data  registered in_rt_data
- out_mem_bus  out  len_mem_bus  registered mem control
- out_wb_bus  out  len_wb_bus  registered wb control
- out_write_reg  out  num_bits  destination register
- out_zero  out  1  registered (result == 0)
- out_pc_branch  out  len_data  registered in_pc_next + (in_imm << 2)
- out_halt  out  1  registered halt
- stall  out  1  hold PC, IF/ID and ID/EX

Behaviour:
- Reset (asynchronous): all outputs and the latch go to 0; HI = LO = 0; md FSM goes to IDLE; stall = 0.
- Latency: one cycle from inputs to registered outputs.
- ALU ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR (all modulo 2^32, no overflow trap)
  - 6 SLT (signed), 7 SLTU; result is 1 or 0
  - 8 SLL, 9 SRL, 10 SRA by in_shamt
  - 11 SLLV, 12 SRLV, 13 SRAV by B[4:0]
  - 14 LUI = {B[15:0], 16'h0}
  - 15 = 0
- Result mux: in_hilo_sel overrides the ALU result with HI or LO. HI/LO reads return the value as of the start of the cycle.
- out_zero is computed from the final result after the HI/LO mux.
- md FSM, states IDLE and BUSY:
  - IDLE -> BUSY when in_md_start && !flush. Operands are captured and a 6-bit counter is loaded with 32.
  - BUSY: one shift-add (MULTU) or restoring-divide (DIVU) step per cycle; counter decrements.
  - BUSY -> IDLE when the counter reaches 0, after exactly 32 BUSY cycles. On that edge HI/LO are written: MULTU {HI,LO} = 64-bit product; DIVU LO = quotient, HI = remainder.
- DIVU by 0: LO = 32'hFFFFFFFF, HI = dividend, still 32 cycles.
- stall = (state == BUSY), combinational.
- While stall = 1 the latch loads a bubble: mem_bus = 0, wb_bus = 0, halt = 0; data fields are don't-care, driven 0.
- The instruction held upstream executes on the first cycle after stall falls.
- The accepting MULTU/DIVU instruction passes through the latch with its own buses. The decoder gives it wb = 0.
- flush (synchronous):
  - The latch loads a bubble.
  - flush in the start cycle cancels the start.
  - flush during BUSY does not abort the computation.
- Priority: reset > stall bubble > flush > normal load.
- in_md_start during BUSY is ignored; the upstream stall holds it until IDLE.

Optional Feature:
- Macro MULDIV_EN.
- Defined: md FSM, HI/LO and stall present as above.
- Undefined:
  - No md logic; stall is tied 0.
  - HI/LO reads return 0.
  - in_md_start and in_md_op are ignored.
  - ALU path and latch are unchanged.

Test Plan:
- Reset mid-BUSY (cycle 10 of MULTU) -> stall = 0 immediately; all outputs 0; HI = LO = 0; FSM IDLE.
- ADD with rs = 5, rt = 7, reg_dst = 1, rd = 3 -> next edge: out_alu_result = 12, out_write_reg = 3, out_zero = 0, buses copied.
- SUB with rs = rt = 9, pc_next = 0x100, imm = 4 -> out_zero = 1, out_pc_branch = 0x110.
- SRA with rt = 0x80000000, shamt = 4 -> 0xF8000000. SLT with -1 vs 1 -> 1. SLTU with 0xFFFFFFFF vs 1 -> 0.
- MULTU 0xFFFFFFFF x 2 -> stall high exactly 32 cycles, latch outputs bubbles meanwhile; then HI = 1, LO = 0xFFFFFFFE. MFHI next -> result 1.
- DIVU 100 / 7 -> LO = 14, HI = 2. DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 5. flush with md_start -> no stall, HI/LO unchanged.
